// File: rtl/posit_pkg.sv
// Shared constants, result classes and field helpers for the posit8 (es=1) to binary16 converter.
package posit_pkg;

  localparam int POSIT_N     = 8;
  localparam int POSIT_ES    = 1;
  localparam int FRAC_W      = 4;
  localparam int REGI_W      = 4;
  localparam int FP16_BIAS   = 15;
  localparam int FP16_EXP_W  = 5;
  // Biased exponent is carried wide enough that range checks see the true value.
  localparam int EXP_W       = POSIT_N - 1;

  localparam logic [15:0] FP16_NAR  = 16'h7E00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef enum logic [2:0] {
    ZERO,
    NAR,
    NORM,
    UFL,
    OFL
  } posit_class_e;

  function automatic logic signed [EXP_W-1:0] biased_exp(
    input logic [REGI_W-1:0] regi,
    input logic              expo
  );
    logic signed [EXP_W-1:0] r;
    r = EXP_W'(signed'(regi));
    biased_exp = (r <<< POSIT_ES) + EXP_W'(expo) + EXP_W'(FP16_BIAS);
  endfunction

  // NaR outranks zero when the decoder flags both.
  function automatic posit_class_e classify(
    input logic                    allzero,
    input logic                    allone,
    input logic signed [EXP_W-1:0] e
  );
    if (allone)
      classify = NAR;
    else if (allzero)
      classify = ZERO;
    else if (e < 7'sd1)
      classify = UFL;
    else if (e > 7'sd30)
      classify = OFL;
    else
      classify = NORM;
  endfunction

endpackage

// File: rtl/posit_fp16_pack.sv
// Combinational packing of a classified posit (class, sign, exponent field, fraction) into binary16.
module posit_fp16_pack
  import posit_pkg::*;
(
  input  posit_class_e            cls,
  input  logic                    sign,
  input  logic [FP16_EXP_W-1:0]   exp_field,
  input  logic [FRAC_W-1:0]       frac,
  output logic [15:0]             fp16
);

  always_comb begin
    fp16 = FP16_ZERO;
    case (cls)
      ZERO:    fp16 = FP16_ZERO;
      NAR:     fp16 = FP16_NAR;
      NORM:    fp16 = {sign, exp_field, frac, 6'b0};
      UFL:     fp16 = {sign, 15'h0};
      OFL:     fp16 = {sign, 5'h1F, 10'h0};
      default: fp16 = FP16_ZERO;
    endcase
  end

endmodule

// File: rtl/posit8_to_fp16.sv
// Two-stage valid/ready pipeline converting decoded posit8 fields to IEEE binary16.
// Optional NaR/zero input counters are built when POSIT_CONV_STATS_EN is defined.
module posit8_to_fp16
  import posit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [REGI_W-1:0] in_regi,
  input  logic              in_expo,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_allzero,
  input  logic              in_allone,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_fp16
`ifdef POSIT_CONV_STATS_EN
  ,
  output logic [7:0]        nar_cnt,
  output logic [7:0]        zero_cnt
`endif
);

  logic                    in_fire;
  logic                    s1_adv;
  logic                    out_fire;
  logic signed [EXP_W-1:0] e_biased;
  posit_class_e            cls_next;

  logic                    s1_valid_reg;
  posit_class_e            s1_cls_reg;
  logic                    s1_sign_reg;
  logic [FP16_EXP_W-1:0]   s1_exp_reg;
  logic [FRAC_W-1:0]       s1_frac_reg;

  logic                    s2_valid_reg;
  logic [15:0]             s2_fp16_reg;
  logic [15:0]             s2_fp16_next;

  assign out_fire = s2_valid_reg && out_ready;
  // S1 may move on whenever S2 is free now or is emptying this cycle.
  assign s1_adv   = s1_valid_reg && (!s2_valid_reg || out_ready);
  assign in_ready = !s1_valid_reg || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign e_biased = biased_exp(in_regi, in_expo);
  assign cls_next = classify(in_allzero, in_allone, e_biased);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_cls_reg   <= ZERO;
      s1_sign_reg  <= 1'b0;
      s1_exp_reg   <= '0;
      s1_frac_reg  <= '0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_cls_reg   <= cls_next;
      s1_sign_reg  <= in_sign;
      s1_exp_reg   <= e_biased[FP16_EXP_W-1:0];
      s1_frac_reg  <= in_frac;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  posit_fp16_pack u_pack (
    .cls       (s1_cls_reg),
    .sign      (s1_sign_reg),
    .exp_field (s1_exp_reg),
    .frac      (s1_frac_reg),
    .fp16      (s2_fp16_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      s2_fp16_reg  <= FP16_ZERO;
    end else if (s1_adv) begin
      s2_valid_reg <= 1'b1;
      s2_fp16_reg  <= s2_fp16_next;
    end else if (out_fire) begin
      s2_valid_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_fp16  = s2_fp16_reg;

`ifdef POSIT_CONV_STATS_EN
  logic [7:0] nar_cnt_reg;
  logic [7:0] zero_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nar_cnt_reg  <= 8'h00;
      zero_cnt_reg <= 8'h00;
    end else if (in_fire) begin
      if (in_allone) begin
        if (nar_cnt_reg != 8'hFF)
          nar_cnt_reg <= nar_cnt_reg + 8'h01;
      end else if (in_allzero) begin
        if (zero_cnt_reg != 8'hFF)
          zero_cnt_reg <= zero_cnt_reg + 8'h01;
      end
    end
  end

  assign nar_cnt  = nar_cnt_reg;
  assign zero_cnt = zero_cnt_reg;
`endif

endmodule

// File: tb/tb_posit8_to_fp16.sv
// Self-checking bench for posit8_to_fp16: vector table with scoreboard, latency, stall, reset
// and (with POSIT_CONV_STATS_EN) counter saturation sequences.
module tb_posit8_to_fp16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [3:0]  in_regi = 4'h0;
  logic        in_expo = 1'b0;
  logic [3:0]  in_frac = 4'h0;
  logic        in_allzero = 1'b0;
  logic        in_allone = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_fp16;
`ifdef POSIT_CONV_STATS_EN
  logic [7:0]  nar_cnt;
  logic [7:0]  zero_cnt;
`endif

  posit8_to_fp16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_regi    (in_regi),
    .in_expo    (in_expo),
    .in_frac    (in_frac),
    .in_allzero (in_allzero),
    .in_allone  (in_allone),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fp16   (out_fp16)
`ifdef POSIT_CONV_STATS_EN
    ,
    .nar_cnt    (nar_cnt),
    .zero_cnt   (zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [3:0]  regi;
    logic        expo;
    logic [3:0]  frac;
    logic        az;
    logic        ao;
    logic [15:0] exp_fp16;
  } vec_t;

  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model written from the arithmetic definition, used for generated stimulus.
  function automatic logic [15:0] model(input logic s, input logic [3:0] r, input logic x,
                                        input logic [3:0] f, input logic az, input logic ao);
    int e;
    e = 2 * int'(signed'(r)) + int'(x) + 15;
    if (ao) return 16'h7E00;
    if (az) return 16'h0000;
    if (e < 1) return {s, 15'h0};
    if (e > 30) return {s, 5'h1F, 10'h0};
    return {s, e[4:0], f, 6'b0};
  endfunction

  // Output-side scoreboard: every output transfer pops one expected value.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %h, required no output", out_fp16);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        $display("xfer out=%h exp=%h", out_fp16, e);
        check("out_fp16", out_fp16, e);
      end
    end
  end

  task automatic send(input logic s, input logic [3:0] r, input logic x, input logic [3:0] f,
                      input logic az, input logic ao, input logic [15:0] e, output bit stalled);
    int waited;
    waited   = 0;
    stalled  = 1'b0;
    in_valid = 1'b1;
    in_sign = s; in_regi = r; in_expo = x; in_frac = f; in_allzero = az; in_allone = ao;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      stalled = 1'b1;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got in_ready=0, required 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check(name, 16'(exp_q.size()), 16'd0);
  endtask

  vec_t vecs[14];

  initial begin
    bit stalled;
    int stalls;
    int accepted;
    int seen_valid;
    logic [15:0] held;

    vecs[0]  = '{"one",        1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h3C00};
    vecs[1]  = '{"three",      1'b0, 4'h0, 1'b1, 4'b1000, 1'b0, 1'b0, 16'h4200};
    vecs[2]  = '{"neg_quart",  1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 1'b0, 16'hB400};
    vecs[3]  = '{"nar_both",   1'b1, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1, 16'h7E00};
    vecs[4]  = '{"zero_neg",   1'b1, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 16'h0000};
    vecs[5]  = '{"ufl",        1'b0, 4'h8, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{"max_e30",    1'b0, 4'h7, 1'b1, 4'b0000, 1'b0, 1'b0, 16'h7800};
    vecs[7]  = '{"max_frac",   1'b0, 4'h7, 1'b1, 4'b1111, 1'b0, 1'b0, 16'h7BC0};
    vecs[8]  = '{"ufl_neg",    1'b1, 4'h8, 1'b0, 4'b0000, 1'b0, 1'b0, 16'h8000};
    vecs[9]  = '{"min_norm",   1'b0, 4'h9, 1'b0, 4'b0101, 1'b0, 1'b0, 16'h0540};
    vecs[10] = '{"ufl_e0",     1'b0, 4'h8, 1'b1, 4'b1111, 1'b0, 1'b0, 16'h0000};
    vecs[11] = '{"mid_neg",    1'b1, 4'h3, 1'b0, 4'b0110, 1'b0, 1'b0, 16'hD580};
    vecs[12] = '{"e14",        1'b0, 4'hF, 1'b1, 4'b0001, 1'b0, 1'b0, 16'h3840};
    vecs[13] = '{"nar_junk",   1'b0, 4'h5, 1'b1, 4'b1111, 1'b0, 1'b1, 16'h7E00};

    // Reset state
    #12;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_fp16", out_fp16, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: transfer at one edge, out_valid after the following edge
    out_ready = 1'b0;
    in_valid = 1'b1; in_sign = 0; in_regi = 4'h0; in_expo = 0; in_frac = 4'h0;
    in_allzero = 0; in_allone = 0;
    @(negedge clk);
    check("lat_in_ready", 16'(in_ready), 16'd1);
    exp_q.push_back(16'h3C00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_valid_c1", 16'(out_valid), 16'd0);
    @(posedge clk); #1;
    check("lat_valid_c2", 16'(out_valid), 16'd1);
    check("lat_data", out_fp16, 16'h3C00);
    out_ready = 1'b1;
    drain("lat_drain");

    // Table vectors back to back
    stalls = 0;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].sign, vecs[i].regi, vecs[i].expo, vecs[i].frac, vecs[i].az, vecs[i].ao,
           vecs[i].exp_fp16, stalled);
      if (stalled) stalls++;
    end
    check("no_bubble_stalls", 16'(stalls), 16'd0);
    drain("table_drain");

    // Back-pressure: 5 cycles of in_valid with out_ready low
    out_ready = 1'b0;
    accepted = 0;
    seen_valid = 0;
    held = 16'h0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_sign = c[0]; in_regi = 4'(c + 1); in_expo = c[1]; in_frac = 4'(c * 3);
      in_allzero = 0; in_allone = 0;
      @(negedge clk);
      if (in_ready) begin
        accepted++;
        exp_q.push_back(model(in_sign, in_regi, in_expo, in_frac, 1'b0, 1'b0));
      end
      if (out_valid) begin
        if (seen_valid == 0) held = out_fp16;
        else check("stall_stable", out_fp16, held);
        seen_valid++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_accepted", 16'(accepted), 16'd2);
    check("stall_in_ready", 16'(in_ready), 16'd0);
    check("stall_out_valid", 16'(out_valid), 16'd1);
    check("stall_held", out_fp16, held);
    out_ready = 1'b1;
    drain("stall_drain");

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(1'b0, 4'h2, 1'b0, 4'h1, 1'b0, 1'b0, model(1'b0, 4'h2, 1'b0, 4'h1, 1'b0, 1'b0), stalled);
    send(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0, model(1'b1, 4'h1, 1'b1, 4'h2, 1'b0, 1'b0), stalled);
    check("pre_rst_in_ready", 16'(in_ready), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 16'(out_valid), 16'd0);
    check("mid_rst_in_ready", 16'(in_ready), 16'd1);
    check("mid_rst_out_fp16", out_fp16, 16'h0000);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("post_rst_no_stale", 16'(seen_valid), 16'd0);
    @(posedge clk); #1;

`ifdef POSIT_CONV_STATS_EN
    check("stats_rst_nar", 16'(nar_cnt), 16'd0);
    for (int i = 0; i < 300; i++)
      send(i[0], 4'(i), i[1], 4'(i), 1'b0, 1'b1, 16'h7E00, stalled);
    drain("stats_drain");
    check("stats_nar_sat", 16'(nar_cnt), 16'h00FF);
    check("stats_zero", 16'(zero_cnt), 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
